// File: rtl/hart_run_ctrl.sv
// hart_run_ctrl
//
// Sequences a single hart through one program execution:
//   1. streams the program bytes into the instruction byte memory,
//   2. holds the hart in reset for RST_CYCLES cycles,
//   3. releases the hart and watches its retire port until it halts or traps
//      (or until the optional watchdog expires),
//   4. reports the cycle count, the retired-instruction count and a final status.
//
// Optional feature macro: RUN_CTRL_WATCHDOG_EN
//   defined   : RUN is aborted with status 11 once o_cycles reaches TIMEOUT_CYCLES
//   undefined : no timeout; RUN lasts until a halt or trap retires
//
// Parameters
//   IMEM_BYTES     instruction byte memory size (address width = clog2)
//   RST_CYCLES     cycles the hart reset is held before each run (>= 1)
//   TIMEOUT_CYCLES run-cycle limit, used only with the watchdog compiled in
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_start, i_len               start command; i_len = 0 reruns the resident program,
//                                values above IMEM_BYTES are clamped
//   i_byte_valid, i_byte_data    program byte stream (little-endian program order)
//   o_byte_ready                 byte accepted when valid & ready
//   o_imem_wen/waddr/wdata       instruction memory byte write port
//   o_hart_rst                   drives the hart's reset input
//   i_retire_valid/trap/halt     hart retire interface
//   o_busy                       high in LOAD, RESET and RUN
//   o_done                       one-cycle pulse on entry to DONE
//   o_status                     00 none, 01 halt, 10 trap, 11 timeout
//   o_cycles, o_retired          saturating RUN-cycle and retired-instruction counters
//
// State  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | after reset; hart held in reset, waiting for i_start
// LOAD   | accepting program bytes and writing them to imem
// RESET  | hart reset held for RST_CYCLES cycles, counters cleared on entry
// RUN    | hart released; counting cycles and retires until halt/trap/timeout
// DONE   | results held, hart back in reset, waiting for the next i_start

module hart_run_ctrl #(
   parameter int unsigned IMEM_BYTES     = 1024,
   parameter int unsigned RST_CYCLES     = 2,
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   localparam int unsigned ADDR_W        = $clog2(IMEM_BYTES)
) (
   input  logic              i_clk,
   input  logic              i_rst,

   input  logic              i_start,
   input  logic [10:0]       i_len,

   input  logic              i_byte_valid,
   input  logic [7:0]        i_byte_data,
   output logic              o_byte_ready,

   output logic              o_imem_wen,
   output logic [ADDR_W-1:0] o_imem_waddr,
   output logic [7:0]        o_imem_wdata,

   output logic              o_hart_rst,
   input  logic              i_retire_valid,
   input  logic              i_retire_trap,
   input  logic              i_retire_halt,

   output logic              o_busy,
   output logic              o_done,
   output logic [1:0]        o_status,
   output logic [31:0]       o_cycles,
   output logic [31:0]       o_retired
);

   localparam int unsigned RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   localparam logic [1:0] ST_NONE    = 2'b00;
   localparam logic [1:0] ST_HALT    = 2'b01;
   localparam logic [1:0] ST_TRAP    = 2'b10;
   localparam logic [1:0] ST_TIMEOUT = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_RESET = 3'd2,
      S_RUN   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_count;
   logic [ADDR_W-1:0] r_last;
   logic [RST_W-1:0]  r_rst_tmr;
   logic              r_byte_ready;
   logic              r_hart_rst;
   logic              r_busy;
   logic              r_done;
   logic [1:0]        r_status;
   logic [31:0]       r_cycles;
   logic [31:0]       r_retired;

   logic [31:0]       w_len_32;
   logic [31:0]       w_len_eff;
   logic              w_accept;
   logic              w_term;
   logic              w_wd_en;
   logic              w_timeout;
   logic [31:0]       w_cycles_inc;
   logic [31:0]       w_retired_inc;

   // Oversized lengths are clamped so the load always fits the memory.
   assign w_len_32  = {21'd0, i_len};
   assign w_len_eff = (w_len_32 > 32'(IMEM_BYTES)) ? 32'(IMEM_BYTES) : w_len_32;

   assign w_accept = r_byte_ready & i_byte_valid;

   // Exit is only evaluated on an actual retire; trap outranks halt.
   assign w_term = i_retire_valid & (i_retire_trap | i_retire_halt);

   assign w_cycles_inc  = (r_cycles  == 32'hFFFF_FFFF) ? r_cycles  : r_cycles  + 32'd1;
   assign w_retired_inc = (r_retired == 32'hFFFF_FFFF) ? r_retired : r_retired + 32'd1;

`ifdef RUN_CTRL_WATCHDOG_EN
   assign w_wd_en = 1'b1;
`else
   assign w_wd_en = 1'b0;
`endif

   // Compare against the post-increment value so the timeout lands with
   // o_cycles == TIMEOUT_CYCLES.
   assign w_timeout = w_wd_en & (w_cycles_inc >= 32'(TIMEOUT_CYCLES));

   // Writes go out in the same cycle the byte is accepted.
   assign o_imem_wen   = w_accept;
   assign o_imem_waddr = r_count;
   assign o_imem_wdata = i_byte_data;

   assign o_byte_ready = r_byte_ready;
   assign o_hart_rst   = r_hart_rst;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_status     = r_status;
   assign o_cycles     = r_cycles;
   assign o_retired    = r_retired;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_count      <= '0;
         r_last       <= '0;
         r_rst_tmr    <= '0;
         r_byte_ready <= 1'b0;
         r_hart_rst   <= 1'b1;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_status     <= ST_NONE;
         r_cycles     <= '0;
         r_retired    <= '0;
      end else begin
         r_done <= 1'b0;

         case (r_state)
            S_IDLE, S_DONE: begin
               r_hart_rst   <= 1'b1;
               r_byte_ready <= 1'b0;
               if (i_start) begin
                  r_busy <= 1'b1;
                  if (w_len_eff != 32'd0) begin
                     r_state      <= S_LOAD;
                     r_count      <= '0;
                     r_last       <= ADDR_W'(w_len_eff - 32'd1);
                     r_byte_ready <= 1'b1;
                  end else begin
                     // Rerun of the resident program: skip the load.
                     r_state   <= S_RESET;
                     r_rst_tmr <= RST_W'(RST_CYCLES - 1);
                     r_status  <= ST_NONE;
                     r_cycles  <= '0;
                     r_retired <= '0;
                  end
               end
            end

            S_LOAD: begin
               if (w_accept) begin
                  r_count <= r_count + 1'b1;
                  if (r_count == r_last) begin
                     r_state      <= S_RESET;
                     r_byte_ready <= 1'b0;
                     r_rst_tmr    <= RST_W'(RST_CYCLES - 1);
                     r_status     <= ST_NONE;
                     r_cycles     <= '0;
                     r_retired    <= '0;
                  end
               end
            end

            S_RESET: begin
               r_hart_rst <= 1'b1;
               if (r_rst_tmr == '0) begin
                  r_state    <= S_RUN;
                  r_hart_rst <= 1'b0;
               end else begin
                  r_rst_tmr <= r_rst_tmr - 1'b1;
               end
            end

            S_RUN: begin
               r_cycles <= w_cycles_inc;
               if (i_retire_valid) begin
                  r_retired <= w_retired_inc;
               end
               if (w_term || w_timeout) begin
                  r_state    <= S_DONE;
                  r_hart_rst <= 1'b1;
                  r_busy     <= 1'b0;
                  r_done     <= 1'b1;
                  if (w_term) begin
                     r_status <= i_retire_trap ? ST_TRAP : ST_HALT;
                  end else begin
                     r_status <= ST_TIMEOUT;
                  end
               end
            end

            default: begin
               r_state      <= S_IDLE;
               r_hart_rst   <= 1'b1;
               r_busy       <= 1'b0;
               r_byte_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hart_run_ctrl.sv
module tb_hart_run_ctrl;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_start;
   logic [10:0] i_len;
   logic        i_byte_valid;
   logic [7:0]  i_byte_data;
   logic        o_byte_ready;
   logic        o_imem_wen;
   logic [9:0]  o_imem_waddr;
   logic [7:0]  o_imem_wdata;
   logic        o_hart_rst;
   logic        i_retire_valid;
   logic        i_retire_trap;
   logic        i_retire_halt;
   logic        o_busy;
   logic        o_done;
   logic [1:0]  o_status;
   logic [31:0] o_cycles;
   logic [31:0] o_retired;

   int checks   = 0;
   int failures = 0;

   localparam logic [7:0] PROG [8] = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h73, 8'h00, 8'h10, 8'h00};

   always #5 clk = ~clk;

   hart_run_ctrl #(
      .IMEM_BYTES     (1024),
      .RST_CYCLES     (2),
      .TIMEOUT_CYCLES (20)
   ) dut (
      .i_clk          (clk),
      .i_rst          (i_rst),
      .i_start        (i_start),
      .i_len          (i_len),
      .i_byte_valid   (i_byte_valid),
      .i_byte_data    (i_byte_data),
      .o_byte_ready   (o_byte_ready),
      .o_imem_wen     (o_imem_wen),
      .o_imem_waddr   (o_imem_waddr),
      .o_imem_wdata   (o_imem_wdata),
      .o_hart_rst     (o_hart_rst),
      .i_retire_valid (i_retire_valid),
      .i_retire_trap  (i_retire_trap),
      .i_retire_halt  (i_retire_halt),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_status       (o_status),
      .o_cycles       (o_cycles),
      .o_retired      (o_retired)
   );

   // Log of every imem write seen at a clock edge.
   logic [9:0] wr_addr [$];
   logic [7:0] wr_data [$];

   always @(posedge clk) begin
      if (o_imem_wen) begin
         wr_addr.push_back(o_imem_waddr);
         wr_data.push_back(o_imem_wdata);
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
      end
   endtask

   // Runs the hart from RUN cycle 1 until it halts on the first retire.
   task automatic finish_run_with_halt;
      i_retire_valid = 1'b1;
      i_retire_halt  = 1'b1;
      step();
      i_retire_valid = 1'b0;
      i_retire_halt  = 1'b0;
   endtask

   task automatic test_reset;
      i_rst = 1'b1;
      step();
      step();
      chk("rst_busy",     32'(o_busy), 32'd0);
      chk("rst_hart_rst", 32'(o_hart_rst), 32'd1);
      chk("rst_done",     32'(o_done), 32'd0);
      chk("rst_status",   32'(o_status), 32'd0);
      chk("rst_cycles",   o_cycles, 32'd0);
      chk("rst_retired",  o_retired, 32'd0);
      chk("rst_ready",    32'(o_byte_ready), 32'd0);
      chk("rst_wen",      32'(o_imem_wen), 32'd0);
      i_rst = 1'b0;
      step();
      chk("idle_busy", 32'(o_busy), 32'd0);
   endtask

   task automatic test_back_to_back;
      int base;
      base    = wr_addr.size();
      i_start = 1'b1;
      i_len   = 11'd8;
      step();
      i_start = 1'b0;
      chk("b2b_ready_on", 32'(o_byte_ready), 32'd1);
      chk("b2b_busy",     32'(o_busy), 32'd1);
      chk("b2b_hart_rst_load", 32'(o_hart_rst), 32'd1);
      for (int k = 0; k < 8; k++) begin
         i_byte_valid = 1'b1;
         i_byte_data  = PROG[k];
         #1;
         chk("b2b_wen",   32'(o_imem_wen), 32'd1);
         chk("b2b_waddr", 32'(o_imem_waddr), 32'(k));
         chk("b2b_wdata", 32'(o_imem_wdata), 32'(PROG[k]));
         step();
      end
      i_byte_valid = 1'b0;
      chk("b2b_ready_9th",  32'(o_byte_ready), 32'd0);
      chk("b2b_hart_rst_1", 32'(o_hart_rst), 32'd1);
      chk("b2b_busy_rst",   32'(o_busy), 32'd1);
      step();
      chk("b2b_hart_rst_2", 32'(o_hart_rst), 32'd1);
      step();
      chk("b2b_hart_rst_run", 32'(o_hart_rst), 32'd0);
      chk("b2b_nwrites", 32'(wr_addr.size() - base), 32'd8);
      for (int k = 0; k < 8; k++) begin
         if (base + k < wr_addr.size()) begin
            chk("b2b_log_addr", 32'(wr_addr[base+k]), 32'(k));
            chk("b2b_log_data", 32'(wr_data[base+k]), 32'(PROG[k]));
         end
      end
   endtask

   // Entered in RUN cycle 1.
   task automatic test_halt;
      for (int c = 1; c <= 5; c++) begin
         i_retire_valid = 1'b1;
         i_retire_halt  = (c == 5);
         step();
      end
      i_retire_valid = 1'b0;
      i_retire_halt  = 1'b0;
      chk("halt_done",     32'(o_done), 32'd1);
      chk("halt_status",   32'(o_status), 32'd1);
      chk("halt_cycles",   o_cycles, 32'd5);
      chk("halt_retired",  o_retired, 32'd5);
      chk("halt_hart_rst", 32'(o_hart_rst), 32'd1);
      chk("halt_busy",     32'(o_busy), 32'd0);
      step();
      chk("halt_done_pulse", 32'(o_done), 32'd0);
      chk("halt_status_hold", 32'(o_status), 32'd1);
      chk("halt_cycles_hold", o_cycles, 32'd5);
   endtask

   task automatic test_stalled_load;
      int base;
      base    = wr_addr.size();
      i_start = 1'b1;
      i_len   = 11'd8;
      step();
      i_start = 1'b0;
      chk("stl_status_kept", 32'(o_status), 32'd1);
      for (int k = 0; k < 8; k++) begin
         i_byte_valid = 1'b1;
         i_byte_data  = PROG[k];
         #1;
         chk("stl_waddr", 32'(o_imem_waddr), 32'(k));
         step();
         if (k < 7) begin
            i_byte_valid = 1'b0;
            i_byte_data  = 8'hFF;
            #1;
            chk("stl_gap_wen", 32'(o_imem_wen), 32'd0);
            step();
         end
      end
      i_byte_valid = 1'b0;
      chk("stl_ready_off", 32'(o_byte_ready), 32'd0);
      chk("stl_status_clr", 32'(o_status), 32'd0);
      chk("stl_cycles_clr", o_cycles, 32'd0);
      step();
      step();
      chk("stl_hart_rst_run", 32'(o_hart_rst), 32'd0);
      chk("stl_nwrites", 32'(wr_addr.size() - base), 32'd8);
      for (int k = 0; k < 8; k++) begin
         if (base + k < wr_addr.size()) begin
            chk("stl_log_addr", 32'(wr_addr[base+k]), 32'(k));
            chk("stl_log_data", 32'(wr_data[base+k]), 32'(PROG[k]));
         end
      end
   endtask

   // Entered in RUN cycle 1. Retires on cycles 1,3,5; a halt without valid on
   // cycle 2 must be ignored; trap+halt on the 3rd retire.
   task automatic test_trap;
      for (int c = 1; c <= 5; c++) begin
         i_retire_valid = (c % 2 == 1);
         i_retire_halt  = (c == 2) || (c == 5);
         i_retire_trap  = (c == 5);
         step();
      end
      i_retire_valid = 1'b0;
      i_retire_halt  = 1'b0;
      i_retire_trap  = 1'b0;
      chk("trap_done",    32'(o_done), 32'd1);
      chk("trap_status",  32'(o_status), 32'd2);
      chk("trap_retired", o_retired, 32'd3);
      chk("trap_cycles",  o_cycles, 32'd5);
   endtask

   task automatic test_watchdog;
      int base;
      base    = wr_addr.size();
      i_start = 1'b1;
      i_len   = 11'd0;
      step();
      i_start = 1'b0;
      chk("wd_ready_off", 32'(o_byte_ready), 32'd0);
      chk("wd_hart_rst",  32'(o_hart_rst), 32'd1);
      // Retires during RESET must be ignored.
      i_retire_valid = 1'b1;
      i_retire_halt  = 1'b1;
      step();
      step();
      i_retire_valid = 1'b0;
      i_retire_halt  = 1'b0;
      chk("wd_in_run",      32'(o_hart_rst), 32'd0);
      chk("wd_retired_ign", o_retired, 32'd0);
      chk("wd_nwrites",     32'(wr_addr.size() - base), 32'd0);
`ifdef RUN_CTRL_WATCHDOG_EN
      begin
         bit seen;
         seen = 1'b0;
         for (int n = 0; n < 100 && !seen; n++) begin
            step();
            seen = o_done;
         end
         chk("wd_done_seen", 32'(seen), 32'd1);
         chk("wd_status",    32'(o_status), 32'd3);
         chk("wd_cycles",    o_cycles, 32'd20);
      end
`else
      repeat (1000) step();
      chk("nowd_busy",     32'(o_busy), 32'd1);
      chk("nowd_hart_rst", 32'(o_hart_rst), 32'd0);
      chk("nowd_status",   32'(o_status), 32'd0);
      chk("nowd_cycles",   o_cycles, 32'd1000);
      i_rst = 1'b1;
      step();
      i_rst = 1'b0;
`endif
   endtask

   task automatic test_abort_rerun;
      int base;
      i_start = 1'b1;
      i_len   = 11'd0;
      step();
      i_start = 1'b0;
      step();
      step();
      step();
      step();
      step();
      chk("abort_cycles_pre", o_cycles, 32'd3);
      i_rst = 1'b1;
      step();
      i_rst = 1'b0;
      chk("abort_busy",     32'(o_busy), 32'd0);
      chk("abort_hart_rst", 32'(o_hart_rst), 32'd1);
      chk("abort_cycles",   o_cycles, 32'd0);
      chk("abort_retired",  o_retired, 32'd0);
      chk("abort_status",   32'(o_status), 32'd0);
      base    = wr_addr.size();
      i_start = 1'b1;
      i_len   = 11'd0;
      step();
      i_start = 1'b0;
      chk("rerun_busy",  32'(o_busy), 32'd1);
      chk("rerun_ready", 32'(o_byte_ready), 32'd0);
      chk("rerun_hart_rst_1", 32'(o_hart_rst), 32'd1);
      step();
      chk("rerun_hart_rst_2", 32'(o_hart_rst), 32'd1);
      step();
      chk("rerun_hart_rst_run", 32'(o_hart_rst), 32'd0);
      finish_run_with_halt();
      chk("rerun_status",  32'(o_status), 32'd1);
      chk("rerun_cycles",  o_cycles, 32'd1);
      chk("rerun_retired", o_retired, 32'd1);
      chk("rerun_nwrites", 32'(wr_addr.size() - base), 32'd0);
   endtask

   task automatic test_clamp;
      int base;
      int errs;
      base    = wr_addr.size();
      errs    = 0;
      i_start = 1'b1;
      i_len   = 11'd1100;
      step();
      i_start = 1'b0;
      for (int k = 0; k < 1024; k++) begin
         i_byte_valid = 1'b1;
         i_byte_data  = 8'(k) ^ 8'h5A;
         step();
      end
      i_byte_valid = 1'b0;
      chk("clamp_ready_off", 32'(o_byte_ready), 32'd0);
      chk("clamp_nwrites",   32'(wr_addr.size() - base), 32'd1024);
      for (int k = 0; k < 1024; k++) begin
         if (base + k < wr_addr.size()) begin
            if (wr_addr[base+k] !== 10'(k) || wr_data[base+k] !== (8'(k) ^ 8'h5A))
               errs++;
         end
      end
      chk("clamp_log_errs", 32'(errs), 32'd0);
      step();
      step();
      finish_run_with_halt();
      chk("clamp_status", 32'(o_status), 32'd1);
   endtask

   initial begin
      i_rst          = 1'b1;
      i_start        = 1'b0;
      i_len          = 11'd0;
      i_byte_valid   = 1'b0;
      i_byte_data    = 8'h00;
      i_retire_valid = 1'b0;
      i_retire_trap  = 1'b0;
      i_retire_halt  = 1'b0;
      test_reset();
      test_back_to_back();
      test_halt();
      test_stalled_load();
      test_trap();
      test_watchdog();
      test_abort_rerun();
      test_clamp();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hart_run_ctrl.md
# hart_run_ctrl

Run controller that sequences one hart through a program execution. It accepts a program as a byte stream and writes it into the instruction-memory byte array. It then holds the hart in reset, releases it, and monitors the retire interface until halt, trap or timeout. Its outputs are a cycle count, a retired-instruction count and a final status. It sits between a host/loader link and the hart plus its instruction memory. It replaces hand-sequenced reset and halt polling.

## Interface
Parameters:
- IMEM_BYTES, 1024: size of the instruction byte memory. Address width is clog2(IMEM_BYTES).
- RST_CYCLES, 2: number of cycles the hart reset is held before a run.
- TIMEOUT_CYCLES, 100000: run-cycle limit. Used only with the watchdog compiled in.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - i_clk  in  1  clock.
  - i_rst  in  1  synchronous active-high reset.
- Command:
  - i_start  in  1  command pulse. Sampled in IDLE or DONE only.
  - i_len  in  11  program length in bytes. 0 means rerun the resident program. Values above IMEM_BYTES are clamped to IMEM_BYTES.
- Byte stream:
  - i_byte_valid  in  1  byte stream valid.
  - i_byte_data  in  8  byte stream data, little-endian program order.
  - o_byte_ready  out  1  byte accepted when valid & ready.
- Instruction memory write:
  - o_imem_wen  out  1  imem byte write enable.
  - o_imem_waddr  out  10  imem byte address.
  - o_imem_wdata  out  8  imem byte data.
- Hart control and retire inputs:
  - o_hart_rst  out  1  drives the hart's i_rst.
  - i_retire_valid  in  1  hart retire valid.
  - i_retire_trap  in  1  hart retire trap.
  - i_retire_halt  in  1  hart retire halt.
- Status:
  - o_busy  out  1  high in LOAD, RESET and RUN.
  - o_done  out  1  one-cycle pulse on entry to DONE.
  - o_status  out  2  00 none, 01 halt, 10 trap, 11 timeout.
  - o_cycles  out  32  RUN cycles counted, saturating.
  - o_retired  out  32  retired instructions, saturating.

## Operation
States are IDLE, LOAD, RESET, RUN and DONE.

- **Reset (i_rst):**
  - State goes to IDLE.
  - o_hart_rst=1.
  - All other outputs are 0, including o_status=00 and both counters.
- **IDLE/DONE:**
  - o_hart_rst=1 and o_byte_ready=0.
  - i_start with an effective length L>0 goes to LOAD. The byte counter is cleared.
  - i_start with i_len=0 goes straight to RESET.
  - i_start in any other state is ignored.
- **LOAD:**
  - o_byte_ready=1.
  - Each accepted byte is written combinationally in the same cycle: o_imem_wen=1, o_imem_waddr=count, o_imem_wdata=i_byte_data. The count then increments.
  - Acceptance of byte L-1 moves to RESET. o_byte_ready drops the following cycle.
  - Gaps in i_byte_valid stall the load indefinitely.
- **RESET:**
  - o_hart_rst=1 for exactly RST_CYCLES cycles.
  - o_cycles, o_retired and o_status are cleared on entry.
  - Then go to RUN.
- **RUN:**
  - o_hart_rst=0.
  - o_cycles increments every cycle.
  - o_retired increments on each i_retire_valid.
  - Both counters saturate at 0xFFFFFFFF.
- **Exit from RUN** is evaluated only when i_retire_valid=1:
  - trap=1 gives status 10. Trap has priority over halt.
  - else halt=1 gives status 01.
  - Either one moves to DONE. The terminating instruction is counted in o_retired, and its cycle is counted in o_cycles.
- **DONE:**
  - o_status and the counters hold until the next run enters RESET.
  - o_hart_rst is reasserted.
- **Retire inputs outside RUN** are ignored.

## Timing
- Load throughput is one byte per cycle with back-to-back valid.
- Cycle after last byte accepted: first RESET cycle.
- o_hart_rst falls on the clock edge RST_CYCLES cycles later. The hart's first instruction fetch occurs in the first RUN cycle.
- Cycle after the terminating retire:
  - state is DONE;
  - o_done=1 for one cycle;
  - o_hart_rst=1.
- i_rst mid-operation (any state) aborts on the next edge:
  - state goes to IDLE;
  - the hart is held in reset;
  - counters and status are cleared;
  - imem contents are not touched.

## Configuration
- RUN_CTRL_WATCHDOG_EN defined:
  - in RUN, when o_cycles reaches TIMEOUT_CYCLES with no terminating retire in that cycle, go to DONE with status 11;
  - a terminating retire in the same cycle wins.
- RUN_CTRL_WATCHDOG_EN undefined:
  - no timeout logic;
  - RUN continues until halt or trap;
  - status 11 is never produced.

## Test plan
- **Back-to-back load:** i_len=8, bytes 0x13,0x05,0x50,0x00,0x73,0x00,0x10,0x00 sent back-to-back. Required:
  - 8 imem writes to addresses 0..7 with matching data;
  - o_byte_ready low on the 9th cycle;
  - o_hart_rst high for 2 cycles, then low.
- **Stalled load:** same load with i_byte_valid toggled every other cycle. Required: identical imem writes, and exactly 8 writes in total.
- **Halt:** halt asserted with valid on the 5th RUN cycle, after 5 retires. Required:
  - o_status=01, o_cycles=5, o_retired=5;
  - one o_done pulse;
  - o_hart_rst=1 in DONE.
- **Trap:** trap and halt asserted together on the 3rd retire. Required: o_status=10, o_retired=3.
- **Watchdog:** built with RUN_CTRL_WATCHDOG_EN and TIMEOUT_CYCLES=20, never halting. Required: o_status=11, o_cycles=20. Without the macro, the controller is still in RUN at cycle 1000.
- **Abort and rerun:**
  - i_rst asserted in RUN cycle 4. Required: IDLE, counters 0, o_hart_rst=1.
  - Then i_start with i_len=0. Required: no imem writes, and the run proceeds directly from RESET.
